// File: rtl/bellek_pkg.sv
// Shared definitions for the wait-state memory responder: base address, FSM encoding,
// row-index helper and LFSR seed.
package bellek_pkg;

  localparam logic [31:0] BELLEK_ADRES = 32'h8000_0000;
  localparam logic [7:0]  LFSR_TOHUM   = 8'hA5;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  // Byte address to word row; the low two address bits are dropped.
  function automatic logic [31:0] satir_indeks(input logic [31:0] adres, input logic [31:0] taban);
    return (adres - taban) >> 2;
  endfunction

endpackage

// File: rtl/gecikme_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick per-request latency; steps when adim=1.
// Zero latency: deger is the current register value; no backpressure.
module gecikme_lfsr
  import bellek_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adim,
  output logic [7:0] deger
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign deger  = lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_TOHUM;
    end else if (adim) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/gecikmeli_bellek.sv
// Word memory with a request/ready handshake; hazir pulses GECIKME cycles after acceptance,
// or a pseudo-random 1..GECIKME when RASTGELE_GECIKME_EN is defined. One request in flight at a time.
module gecikmeli_bellek
  import bellek_pkg::*;
#(
  parameter logic [31:0] BELLEK_ADRES = bellek_pkg::BELLEK_ADRES,
  parameter int          ADRES_BIT    = 32,
  parameter int          VERI_BIT     = 32,
  parameter int          SATIR_SAYISI = 1024,
  parameter int          GECIKME      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADRES_BIT-1:0] adres,
  input  logic                 istek_gecerli,
  input  logic                 yaz_gecerli,
  input  logic [VERI_BIT-1:0]  yaz_veri,
  output logic [VERI_BIT-1:0]  oku_veri,
  output logic                 hazir
);

  localparam int SATIR_BIT = $clog2(SATIR_SAYISI);

  logic [VERI_BIT-1:0] bellek [SATIR_SAYISI];

  durum_t               simdiki_durum_r;
  logic [3:0]           sayac_q;
  logic                 hazir_q;
  logic                 yaz_q;
  logic                 aralik_q;
  logic [SATIR_BIT-1:0] satir_q;
  logic [VERI_BIT-1:0]  veri_q;

  logic [3:0]  gecikme_d;
  logic [31:0] satir_d;
  logic        aralik_d;
  logic        kabul;

  assign kabul    = (simdiki_durum_r == BOSTA) && istek_gecerli;
  assign satir_d  = satir_indeks(32'(adres), BELLEK_ADRES);
  assign aralik_d = (32'(adres) >= BELLEK_ADRES) && (satir_d < 32'(SATIR_SAYISI));

`ifdef RASTGELE_GECIKME_EN
  logic [7:0] lfsr_deger;

  gecikme_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adim  (kabul),
    .deger (lfsr_deger)
  );

  // Latency uses the LFSR value before this request's step.
  assign gecikme_d = 4'(32'd1 + (32'(lfsr_deger) % 32'(GECIKME)));
`else
  assign gecikme_d = 4'(GECIKME);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      simdiki_durum_r <= BOSTA;
      sayac_q         <= '0;
      hazir_q         <= 1'b0;
      yaz_q           <= 1'b0;
      aralik_q        <= 1'b0;
      satir_q         <= '0;
      veri_q          <= '0;
    end else begin
      case (simdiki_durum_r)
        BOSTA: begin
          if (kabul) begin
            yaz_q    <= yaz_gecerli;
            aralik_q <= aralik_d;
            satir_q  <= satir_d[SATIR_BIT-1:0];
            veri_q   <= yaz_veri;
            sayac_q  <= gecikme_d - 4'd1;
            if (gecikme_d == 4'd1) begin
              simdiki_durum_r <= YANIT;
              hazir_q         <= 1'b1;
            end else begin
              simdiki_durum_r <= BEKLE;
            end
          end
        end
        BEKLE: begin
          if (sayac_q == 4'd1) begin
            simdiki_durum_r <= YANIT;
            hazir_q         <= 1'b1;
          end
          sayac_q <= sayac_q - 4'd1;
        end
        YANIT: begin
          simdiki_durum_r <= BOSTA;
          hazir_q         <= 1'b0;
        end
        default: begin
          simdiki_durum_r <= BOSTA;
          hazir_q         <= 1'b0;
        end
      endcase
    end
  end

  // Commit on the edge ending YANIT; a reset on that edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && (simdiki_durum_r == YANIT) && yaz_q && aralik_q) begin
      bellek[satir_q] <= veri_q;
    end
  end

  assign hazir    = hazir_q;
  assign oku_veri = (hazir_q && !yaz_q && aralik_q) ? bellek[satir_q] : '0;

endmodule

// File: doc/gecikmeli_bellek.md
Name: gecikmeli_bellek

Overview:
- Memory responder with a programmable wait-state model, for exercising the processor's stall path.
- Replaces the zero-latency main memory on the processor bus, adding a request/ready handshake.
- Holds word-addressed storage; the testbench preloads and inspects it by backdoor through the internal array `bellek`.

Parameters:
- BELLEK_ADRES, 32'h8000_0000, byte address mapped to row 0.
- ADRES_BIT, 32, address width.
- VERI_BIT, 32, data width; one row holds one word.
- SATIR_SAYISI, 1024, number of storage rows.
- GECIKME, 3, wait cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- adres  input  ADRES_BIT  byte address from the processor.
- istek_gecerli  input  1  request valid.
- yaz_gecerli  input  1  1 = write, 0 = read; sampled with istek_gecerli.
- yaz_veri  input  VERI_BIT  write data.
- oku_veri  output  VERI_BIT  read data; valid only while hazir=1.
- hazir  output  1  one-cycle completion strobe.

Behaviour:
- States: BOSTA, BEKLE, YANIT. The state register is named simdiki_durum_r.
- Reset (one clk edge with rst=1):
  - state goes to BOSTA; hazir=0; oku_veri=0; wait counter=0.
  - Storage contents are untouched.
  - Reset overrides every other input on that edge.
- BOSTA:
  - istek_gecerli=1 accepts the request: adres, yaz_gecerli and yaz_veri are latched; counter loads GECIKME-1.
  - Next state is YANIT if the loaded latency is 1, otherwise BEKLE.
  - istek_gecerli=0: stay in BOSTA.
- BEKLE:
  - Counter decrements each cycle; when it reaches 1, next state is YANIT.
  - Input changes are ignored, since the request is already latched.
- YANIT (exactly one cycle, hazir=1):
  - Read: oku_veri = bellek[row], combinational from the latched row.
  - Write: bellek[row] <= latched yaz_veri at the edge ending YANIT; oku_veri=0.
  - Next state is always BOSTA; istek_gecerli is ignored in this cycle.
- Latency:
  - hazir rises exactly GECIKME cycles after the accepting edge.
  - Minimum request-to-request spacing is GECIKME+1 cycles, because BOSTA always lasts at least one cycle.
- Row index = (adres - BELLEK_ADRES) >> 2; bits [1:0] are ignored, so misaligned addresses are truncated.
- Out-of-range addresses (adres below BELLEK_ADRES, or row >= SATIR_SAYISI):
  - the handshake completes normally with hazir=1;
  - a read returns 0; a write is dropped.
- Outside YANIT, hazir=0 and oku_veri=0.
- Reset in BEKLE or YANIT: the pending request is aborted and a pending write is not committed; the next request is accepted from BOSTA.
- The processor must hold istek_gecerli high until it sees hazir and drop it before the following BOSTA cycle. Otherwise a high istek_gecerli in that BOSTA cycle is taken as a new request.

Optional Feature:
- Macro: RASTGELE_GECIKME_EN.
- Defined:
  - An 8-bit Fibonacci LFSR with taps 8,6,5,4 is reset to 8'hA5 and steps once per accepted request.
  - Per-request latency = 1 + (lfsr % GECIKME), using the LFSR value before the step; range 1..GECIKME.
  - Handshake and state rules are otherwise unchanged.
- Undefined: latency is fixed at GECIKME and no LFSR logic exists.

Decomposition:
- Shared package bellek_pkg holds:
  - BELLEK_ADRES;
  - the state encoding (BOSTA=2'd0, BEKLE=2'd1, YANIT=2'd2);
  - the row-index function;
  - the LFSR seed 8'hA5.
- One sub-module, gecikme_lfsr: clk, rst, adim input, deger[7:0] output; instantiated only under RASTGELE_GECIKME_EN.

Test Plan:
- Reset: preload row 0 = 32'h200; hold rst 10 cycles -> hazir=0, oku_veri=0, state BOSTA, row 0 still 32'h200.
- Read: GECIKME=3, read 32'h8000_0204 holding 32'h400 -> hazir=1 exactly 3 cycles after accept, oku_veri=32'h400 for one cycle, then 0.
- Write then read:
  - write 32'hDBDBDB to 32'h8000_0410 -> bellek[260]=32'hDBDBDB after the YANIT edge;
  - a following read of the same address returns 32'hDBDBDB.
- Out of range: read 32'h7FFF_FFFC and write 32'h8000_1000 -> hazir asserted on schedule, read data 0, no storage row modified.
- Reset mid-write: assert rst in a BEKLE cycle of a write of 32'hFFFF_FFFF to 32'h8000_0300 -> row 192 unchanged, no hazir pulse, the next read completes normally.
- With RASTGELE_GECIKME_EN and GECIKME=4, 20 back-to-back reads:
  - every latency is in 1..4;
  - the sequence matches the LFSR model seeded 8'hA5;
  - data is correct for each read.
